// File: rtl/psk4_demod.sv
// ---------------------------------------------------------------------------
// psk4_demod
// Coherent QPSK demodulator for a carrier locked at fs/4 relative to the
// sample strobe. Each sample is mixed by {+1,0,-1,0} on I and {0,+1,0,-1}
// on Q, which reduces to adding or subtracting the sample into one of two
// accumulators. The accumulators integrate over SPS samples and are then
// dumped into the soft outputs, with a hard bit decision taken from the sign.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous reset, active-high
//   i_sample_valid sample strobe; clock enable for the whole datapath
//   i_sample_in    signed received sample (WIDTH bits)
//   i_sym_start    this sample (or the next valid one) is sample 0 of a symbol
//   o_sym_valid    one-cycle pulse: o_s1/o_s2/o_i_soft/o_q_soft are new
//   o_s1           cosine bit decision (1 when o_i_soft >= 0)
//   o_s2           sine bit decision (1 when o_q_soft >= 0)
//   o_i_soft       signed I integrate result of the last symbol (ACC_W bits)
//   o_q_soft       signed Q integrate result of the last symbol (ACC_W bits)
//   o_busy         high while integrating symbols
// ---------------------------------------------------------------------------
module psk4_demod #(
    parameter int WIDTH = 12,
    parameter int SPS   = 8,
    parameter int ACC_W = WIDTH + $clog2(SPS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_sample_valid,
    input  logic signed [WIDTH-1:0] i_sample_in,
    input  logic                    i_sym_start,
    output logic                    o_sym_valid,
    output logic                    o_s1,
    output logic                    o_s2,
    output logic signed [ACC_W-1:0] o_i_soft,
    output logic signed [ACC_W-1:0] o_q_soft,
    output logic                    o_busy
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(SPS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_INTEG = 1'b1
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   r_i_acc;
    logic signed [ACC_W-1:0]   r_q_acc;
    logic                      r_sym_valid;
    logic                      r_s1;
    logic                      r_s2;
    logic signed [ACC_W-1:0]   r_i_soft;
    logic signed [ACC_W-1:0]   r_q_soft;

    logic                      w_last_hit;
    logic                      w_restart;
    logic                      w_active;
    logic [CNT_W-1:0]          w_k;
    logic signed [ACC_W-1:0]   w_x_ext;
    logic signed [ACC_W-1:0]   w_i_base;
    logic signed [ACC_W-1:0]   w_q_base;
    logic signed [ACC_W-1:0]   w_i_next;
    logic signed [ACC_W-1:0]   w_q_next;

    // Sample index, accumulator bases and the mixed/accumulated next sums.
    always_comb begin
        w_last_hit = 1'b0;
        w_restart  = 1'b0;
        w_active   = 1'b0;
        w_k        = r_cnt;
        w_i_base   = r_i_acc;
        w_q_base   = r_q_acc;
        w_i_next   = r_i_acc;
        w_q_next   = r_q_acc;
        w_x_ext    = {{(ACC_W - WIDTH){i_sample_in[WIDTH-1]}}, i_sample_in};

        // A sym_start arriving with the last sample of a symbol must not steal
        // that sample: the symbol completes and the resync is implicit because
        // the counter wraps to zero anyway.
        w_last_hit = (r_state == S_INTEG) && i_sample_valid && (r_cnt == LAST_K);
        w_restart  = i_sym_start && !w_last_hit;
        w_active   = (r_state == S_INTEG) || i_sym_start;

        if (w_restart) begin
            w_k      = '0;
            w_i_base = '0;
            w_q_base = '0;
        end else begin
            w_k      = r_cnt;
            w_i_base = r_i_acc;
            w_q_base = r_q_acc;
        end

        // SPS is a multiple of 4, so the carrier phase is the low two index bits.
        case (w_k[1:0])
            2'd0: begin
                w_i_next = w_i_base + w_x_ext;
                w_q_next = w_q_base;
            end
            2'd1: begin
                w_i_next = w_i_base;
                w_q_next = w_q_base + w_x_ext;
            end
            2'd2: begin
                w_i_next = w_i_base - w_x_ext;
                w_q_next = w_q_base;
            end
            2'd3: begin
                w_i_next = w_i_base;
                w_q_next = w_q_base - w_x_ext;
            end
            default: begin
                w_i_next = w_i_base;
                w_q_next = w_q_base;
            end
        endcase
    end

    // FSM, integrate-and-dump datapath and registered symbol outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_i_acc     <= '0;
            r_q_acc     <= '0;
            r_sym_valid <= 1'b0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_i_soft    <= '0;
            r_q_soft    <= '0;
        end else begin
            r_sym_valid <= 1'b0;
            if (w_active) begin
                r_state <= S_INTEG;
                if (i_sample_valid) begin
                    if (w_k == LAST_K) begin
                        // Dump: no extra cycle, the next sample is k=0 again.
                        r_i_soft    <= w_i_next;
                        r_q_soft    <= w_q_next;
                        r_s1        <= ~w_i_next[ACC_W-1];
                        r_s2        <= ~w_q_next[ACC_W-1];
                        r_sym_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_i_acc     <= '0;
                        r_q_acc     <= '0;
                    end else begin
                        r_cnt   <= w_k + CNT_W'(1);
                        r_i_acc <= w_i_next;
                        r_q_acc <= w_q_next;
                    end
                end else begin
                    // No sample: hold, except a restart clears the partial symbol.
                    r_cnt   <= w_k;
                    r_i_acc <= w_i_base;
                    r_q_acc <= w_q_base;
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign o_sym_valid = r_sym_valid;
    assign o_s1        = r_s1;
    assign o_s2        = r_s2;
    assign o_i_soft    = r_i_soft;
    assign o_q_soft    = r_q_soft;
    assign o_busy      = (r_state == S_INTEG);

endmodule

// File: tb/tb_psk4_demod.sv
// ---------------------------------------------------------------------------
// tb_psk4_demod
// Self-checking bench for psk4_demod (WIDTH=12, SPS=8, ACC_W=15). A symbol
// level reference keeps the samples of the current symbol in a queue and,
// when SPS samples have been collected, correlates them with cos/sin of the
// fs/4 carrier. A compare process checks every DUT output against it after
// every clock edge; directed cases add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_psk4_demod;

    localparam int WIDTH = 12;
    localparam int SPS   = 8;
    localparam int ACC_W = 15;

    logic                    clk;
    logic                    rst;
    logic                    i_sample_valid;
    logic signed [WIDTH-1:0] i_sample_in;
    logic                    i_sym_start;
    logic                    o_sym_valid;
    logic                    o_s1;
    logic                    o_s2;
    logic signed [ACC_W-1:0] o_i_soft;
    logic signed [ACC_W-1:0] o_q_soft;
    logic                    o_busy;

    psk4_demod #(.WIDTH(WIDTH), .SPS(SPS), .ACC_W(ACC_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample_valid (i_sample_valid),
        .i_sample_in    (i_sample_in),
        .i_sym_start    (i_sym_start),
        .o_sym_valid    (o_sym_valid),
        .o_s1           (o_s1),
        .o_s2           (o_s2),
        .o_i_soft       (o_i_soft),
        .o_q_soft       (o_q_soft),
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_pulse = 0;
    bit chk_en  = 1'b0;

    // Reference model state
    bit in_sym;
    int smp[$];
    int exp_valid, exp_s1, exp_s2, exp_i, exp_q, exp_busy;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int cosv(input int k);
        case (k % 4)
            0:       return 1;
            2:       return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int sinv(input int k);
        case (k % 4)
            1:       return 1;
            3:       return -1;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        in_sym = 1'b0;
        smp.delete();
        exp_valid = 0; exp_s1 = 0; exp_s2 = 0;
        exp_i = 0; exp_q = 0; exp_busy = 0;
    endfunction

    // Expected outputs after the coming clock edge for the given inputs.
    function automatic void model_step(input bit v, input int x, input bit st);
        int isum, qsum;
        exp_valid = 0;
        if (st && !(in_sym && v && smp.size() == SPS - 1)) begin
            smp.delete();
            in_sym = 1'b1;
        end
        if (in_sym && v) begin
            smp.push_back(x);
            if (smp.size() == SPS) begin
                isum = 0;
                qsum = 0;
                for (int k = 0; k < SPS; k++) begin
                    isum += smp[k] * cosv(k);
                    qsum += smp[k] * sinv(k);
                end
                exp_valid = 1;
                exp_i  = isum;
                exp_q  = qsum;
                exp_s1 = (isum >= 0) ? 1 : 0;
                exp_s2 = (qsum >= 0) ? 1 : 0;
                smp.delete();
            end
        end
        exp_busy = in_sym ? 1 : 0;
    endfunction

    // Compare every DUT output against the model after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("sym_valid", int'(o_sym_valid), exp_valid);
            chk("busy",      int'(o_busy),      exp_busy);
            chk("i_soft",    int'(o_i_soft),    exp_i);
            chk("q_soft",    int'(o_q_soft),    exp_q);
            chk("s1",        int'(o_s1),        exp_s1);
            chk("s2",        int'(o_s2),        exp_s2);
        end
    end

    // Count output pulses for the pulse-count checks.
    always @(posedge clk) begin
        #1;
        if (o_sym_valid) n_pulse++;
    end

    task automatic cycle(input bit v, input int x, input bit st);
        logic [31:0] xv;
        @(negedge clk);
        xv = x;
        i_sample_valid = v;
        i_sample_in    = xv[WIDTH-1:0];
        i_sym_start    = st;
        model_step(v, x, st);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    // Send one 4-sample pattern repeated twice; sym_start on the first sample.
    task automatic send_sym(input int a, input int b, input int c, input int d,
                            input bit with_start, input int gap);
        int pat[4];
        pat = '{a, b, c, d};
        for (int k = 0; k < SPS; k++) begin
            cycle(1'b1, pat[k % 4], with_start && (k == 0));
            if (k != SPS - 1) idle_cycles(gap);
        end
    endtask

    task automatic expect_sym(input string name, input int ei, input int eq,
                              input int es1, input int es2);
        chk({name, "_valid"}, int'(o_sym_valid), 1);
        chk({name, "_i"},     int'(o_i_soft),    ei);
        chk({name, "_q"},     int'(o_q_soft),    eq);
        chk({name, "_s1"},    int'(o_s1),        es1);
        chk({name, "_s2"},    int'(o_s2),        es2);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", int'(o_sym_valid), 0);
        chk("rst_busy",  int'(o_busy),      0);
        chk("rst_i",     int'(o_i_soft),    0);
        chk("rst_q",     int'(o_q_soft),    0);
        chk("rst_s1",    int'(o_s1),        0);
        chk("rst_s2",    int'(o_s2),        0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int p0, v, st, x;

    initial begin
        rst = 1'b1;
        i_sample_valid = 1'b0;
        i_sample_in    = '0;
        i_sym_start    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2);

        // 1: async reset mid-clock after some activity
        send_sym(300, -100, 200, 50, 1'b1, 0);
        async_reset();
        idle_cycles(1);

        // 2: basic symbol
        send_sym(500, 500, -500, -500, 1'b1, 0);
        expect_sym("t2", 2000, 2000, 1, 1);

        // 3: back-to-back symbols, pulses exactly 8 samples apart
        p0 = n_pulse;
        send_sym(500, -500, -500, 500, 1'b1, 0);
        expect_sym("t3a", 2000, -2000, 1, 0);
        send_sym(-500, -500, 500, 500, 1'b0, 0);
        expect_sym("t3b", -2000, -2000, 0, 0);
        chk("t3_pulses", n_pulse - p0, 2);

        // 4: gaps of 3 cycles between samples
        p0 = n_pulse;
        send_sym(500, 500, -500, -500, 1'b1, 3);
        expect_sym("t4", 2000, 2000, 1, 1);
        idle_cycles(4);
        chk("t4_pulses", n_pulse - p0, 1);
        chk("t4_hold_i", int'(o_i_soft), 2000);

        // 5: full scale and zero tie
        send_sym(-2048, 0, 2047, 0, 1'b1, 0);
        expect_sym("t5", -8190, 0, 0, 1);

        // 6a: resync at k=5 discards partial symbol
        p0 = n_pulse;
        cycle(1'b1, 1000, 1'b1);
        for (int k = 1; k < 5; k++) cycle(1'b1, 1000, 1'b0);
        send_sym(-100, 200, 100, -200, 1'b1, 0);
        expect_sym("t6a", -400, 800, 0, 1);
        chk("t6a_pulses", n_pulse - p0, 1);

        // 6b: sym_start on the last sample still emits, resync from next sample
        p0 = n_pulse;
        cycle(1'b1, 10, 1'b1);
        for (int k = 1; k < SPS - 1; k++) cycle(1'b1, 10, 1'b0);
        cycle(1'b1, 10, 1'b1);
        expect_sym("t6b", 0, 0, 1, 1);
        send_sym(7, 0, 0, 0, 1'b0, 0);
        expect_sym("t6b2", 14, 0, 1, 1);
        chk("t6b_pulses", n_pulse - p0, 2);

        // 6c: reset at k=3, then stay idle until sym_start
        p0 = n_pulse;
        cycle(1'b1, 50, 1'b1);
        cycle(1'b1, 50, 1'b0);
        cycle(1'b1, 50, 1'b0);
        async_reset();
        for (int k = 0; k < 10; k++) cycle(1'b1, 123, 1'b0);
        chk("t6c_pulses", n_pulse - p0, 0);
        chk("t6c_busy",   int'(o_busy), 0);

        // Randomized traffic with occasional resyncs
        cycle(1'b1, 0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            v  = ($urandom_range(3) != 0) ? 1 : 0;
            st = ($urandom_range(29) == 0) ? 1 : 0;
            x  = int'($urandom_range(4095)) - 2048;
            cycle(v[0], x, st[0]);
        end
        idle_cycles(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
